// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read port / board pin and the UART transmitter.
// master = FIFO + board side, slave = transmitter.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       rdempty;
    logic [7:0] q;
    logic       rdreq;
    logic       txd;
    logic       busy;
    logic       tx_done;

    modport master (
        output tx_en, rdempty, q,
        input  rdreq, txd, busy, tx_done
    );

    modport slave (
        input  tx_en, rdempty, q,
        output rdreq, txd, busy, tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a normal-mode FIFO (q valid the cycle after rdreq) and shifts
// each one out on txd as a UART 8N1 frame, LSB first.
module fifo_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_uart_tx_if.slave  tx_if
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);

    typedef enum logic [2:0] {IDLE, REQ, FETCH, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          txd_q;
    logic          rdreq_q;
    logic          busy_q;
    logic          done_q;

    logic baud_wrap;
    assign baud_wrap = (baud_q == BAUD_LAST);

    // Outputs are loaded alongside the state they belong to, so each one is
    // a registered image of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            rdreq_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rdreq_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_if.tx_en && !tx_if.rdempty) begin
                        state_q <= REQ;
                        rdreq_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: state_q <= FETCH;
                FETCH: begin
                    sh_q    <= tx_if.q;
                    baud_q  <= '0;
                    txd_q   <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        sh_q   <= sh_q >> 1;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q <= sh_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the last stop cycle.
                    if (baud_q == BAUD_PRE) done_q <= 1'b1;
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.txd     = txd_q;
    assign tx_if.rdreq   = rdreq_q;
    assign tx_if.busy    = busy_q;
    assign tx_if.tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at BAUD_DIV=4 (40-cycle frames) with a small
// normal-mode FIFO model on the read side.
module tb_fifo_uart_tx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_uart_tx_if ifc ();

    fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(250_000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (ifc.slave)
    );

    always #5 clk = ~clk;

    // FIFO model: q registered one cycle after rdreq
    logic [7:0] mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] q_r    = 8'h00;

    assign ifc.rdempty = (rd_ptr == wr_ptr);
    assign ifc.q       = q_r;

    always @(posedge clk) begin
        if (ifc.rdreq === 1'b1) begin
            q_r    <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int rdreq_n = 0;
    int done_n  = 0;
    int viol_n  = 0;

    always @(negedge clk) begin
        if (ifc.rdreq === 1'b1) rdreq_n <= rdreq_n + 1;
        if (ifc.tx_done === 1'b1) done_n <= done_n + 1;
        if (ifc.rdreq === 1'b1 && ifc.rdempty === 1'b1) viol_n <= viol_n + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic wait_start(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            gap++;
        end
    endtask

    // Captures one 40-cycle frame from its first start cycle; optional tx_en drop.
    task automatic frame(input logic [7:0] b, input int drop_at, input string tag, output int gap);
        bit          ok;
        logic [39:0] got_v, exp_v, dn_v, dexp_v;
        wait_start(gap, ok);
        chk({tag, " start"}, 64'(ok), 64'd1);
        if (ok) begin
            got_v[0] = ifc.txd;
            dn_v[0]  = ifc.tx_done;
            for (int i = 1; i < 40; i++) begin
                @(negedge clk);
                if (i == drop_at) ifc.tx_en = 1'b0;
                got_v[i] = ifc.txd;
                dn_v[i]  = ifc.tx_done;
            end
            for (int i = 0; i < 40; i++) begin
                if (i < 4)       exp_v[i] = 1'b0;
                else if (i < 36) exp_v[i] = b[(i - 4) / 4];
                else             exp_v[i] = 1'b1;
                dexp_v[i] = (i == 39);
            end
            chk({tag, " txd"}, 64'(got_v), 64'(exp_v));
            chk({tag, " tx_done"}, 64'(dn_v), 64'(dexp_v));
        end
    endtask

    initial begin
        int  gap;
        int  base_r, base_d, bad;
        bit  ok, seen;

        ifc.tx_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst txd", 64'(ifc.txd), 64'd1);
        chk("rst rdreq", 64'(ifc.rdreq), 64'd0);
        chk("rst busy", 64'(ifc.busy), 64'd0);
        chk("rst tx_done", 64'(ifc.tx_done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte 0xA5
        base_r = rdreq_n;
        base_d = done_n;
        push(8'hA5);
        ifc.tx_en = 1'b1;
        frame(8'hA5, -1, "a5", gap);
        repeat (2) @(negedge clk);
        chk("a5 rdreq count", 64'(rdreq_n - base_r), 64'd1);
        chk("a5 done count", 64'(done_n - base_d), 64'd1);
        chk("a5 busy after", 64'(ifc.busy), 64'd0);

        // three back-to-back bytes
        base_r = rdreq_n;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        frame(8'h00, -1, "b00", gap);
        frame(8'hFF, -1, "bff", gap);
        chk("gap 00-ff", 64'(gap), 64'd3);
        frame(8'h55, -1, "b55", gap);
        chk("gap ff-55", 64'(gap), 64'd3);
        repeat (2) @(negedge clk);
        chk("b2b rdreq count", 64'(rdreq_n - base_r), 64'd3);

        // empty FIFO for 1000 cycles
        base_r = rdreq_n;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ifc.rdreq !== 1'b0 || ifc.txd !== 1'b1 || ifc.busy !== 1'b0) bad++;
        end
        chk("empty idle", 64'(bad), 64'd0);
        chk("empty rdreq count", 64'(rdreq_n - base_r), 64'd0);

        // tx_en dropped at data bit 2 of 0x3C
        base_r = rdreq_n;
        push(8'h3C);
        push(8'h81);
        frame(8'h3C, 12, "b3c", gap);
        repeat (20) @(negedge clk);
        chk("en0 rdreq count", 64'(rdreq_n - base_r), 64'd1);
        chk("en0 busy", 64'(ifc.busy), 64'd0);
        chk("en0 txd", 64'(ifc.txd), 64'd1);
        ifc.tx_en = 1'b1;
        @(negedge clk);
        chk("en1 rdreq next clk", 64'(ifc.rdreq), 64'd1);
        frame(8'h81, -1, "b81", gap);
        chk("b81 gap", 64'(gap), 64'd1);

        // reset during data bit 3 of 0xF0
        base_r = rdreq_n;
        push(8'hF0);
        push(8'h5A);
        wait_start(gap, ok);
        chk("f0 start", 64'(ok), 64'd1);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst txd", 64'(ifc.txd), 64'd1);
        chk("midrst rdreq", 64'(ifc.rdreq), 64'd0);
        chk("midrst busy", 64'(ifc.busy), 64'd0);
        chk("midrst tx_done", 64'(ifc.tx_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.rdreq === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("post-rst rdreq", 64'(seen), 64'd1);
        frame(8'h5A, -1, "b5a", gap);
        chk("b5a gap", 64'(gap), 64'd1);
        repeat (2) @(negedge clk);
        chk("rst rdreq count", 64'(rdreq_n - base_r), 64'd2);
        chk("rdreq while empty", 64'(viol_n), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
